// File: rtl/counter_mod_n.sv
// Parametrised synchronous modulo-N counter ('163 control model) with registered wrap flag.
// Optional down counting is enabled by defining COUNTER_MOD_DOWN_EN.
module counter_mod_n #(
  parameter int          WIDTH   = 8,
  parameter int unsigned MODULUS = 2**WIDTH,
  parameter int unsigned INIT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             pe_n,
  input  logic             cet,
  input  logic             cep,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $fatal(1, "counter_mod_n: illegal WIDTH/MODULUS combination");
  end
  if (INIT >= MODULUS) begin : g_bad_init
    $fatal(1, "counter_mod_n: INIT must be below MODULUS");
  end

  // Terminal value held in WIDTH+1 bits so MODULUS = 2**WIDTH stays exact.
  localparam logic [WIDTH:0]   L_TERM   = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] L_TERM_Q = L_TERM[WIDTH-1:0];
  localparam logic [WIDTH-1:0] L_INIT   = WIDTH'(INIT);
  localparam logic [WIDTH:0]   L_ONE    = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_up_q;
  logic             w_up_wrap;
  logic [WIDTH-1:0] w_cnt_q;
  logic             w_cnt_wrap;
  logic             w_tc_hit;
  logic             w_unused_bits;

  assign w_q_ext = {1'b0, r_q};
  assign w_sum   = w_q_ext + L_ONE;

  always_comb begin
    w_up_q    = w_sum[WIDTH-1:0];
    w_up_wrap = 1'b0;
    // Anything at or above the terminal value (including loaded out-of-range data) wraps to 0.
    if (w_q_ext >= L_TERM) begin
      w_up_q    = '0;
      w_up_wrap = 1'b1;
    end
  end

`ifdef COUNTER_MOD_DOWN_EN
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_dn_q;
  logic             w_dn_wrap;
  logic             w_unused_diff;

  assign w_diff        = w_q_ext - L_ONE;
  assign w_unused_diff = w_diff[WIDTH];

  always_comb begin
    w_dn_q    = w_diff[WIDTH-1:0];
    w_dn_wrap = 1'b0;
    if (r_q == '0) begin
      w_dn_q    = L_TERM_Q;
      w_dn_wrap = 1'b1;
    end else if (w_q_ext > L_TERM) begin
      // Out-of-range value re-enters the range at the top without flagging a wrap.
      w_dn_q    = L_TERM_Q;
      w_dn_wrap = 1'b0;
    end
  end

  always_comb begin
    w_cnt_q    = dir ? w_up_q    : w_dn_q;
    w_cnt_wrap = dir ? w_up_wrap : w_dn_wrap;
    w_tc_hit   = dir ? (w_q_ext == L_TERM) : (r_q == '0);
  end
`else
  always_comb begin
    w_cnt_q    = w_up_q;
    w_cnt_wrap = w_up_wrap;
    w_tc_hit   = (w_q_ext == L_TERM);
  end
`endif

  assign w_unused_bits = dir ^ w_sum[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= L_INIT;
      r_wrap <= 1'b0;
    end else if (!pe_n) begin
      r_q    <= d;
      r_wrap <= 1'b0;
    end else if (cet && cep) begin
      r_q    <= w_cnt_q;
      r_wrap <= w_cnt_wrap;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign tc   = cet & w_tc_hit;

endmodule

// File: tb/tb_counter_mod_n.sv
// Self-checking bench for counter_mod_n: directed scenarios plus randomized stimulus
// compared against an arithmetic reference model; covers default and COUNTER_MOD_DOWN_EN builds.
module tb_counter_mod_n;

`ifdef COUNTER_MOD_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int exp_q[$];

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one rising edge following the priority rules.
  task automatic model_edge(input int m, input int init, input bit rst, input bit pe_n,
                            input bit cet, input bit cep, input bit dir, input int d,
                            inout int q, inout bit w);
    if (rst) begin
      q = init; w = 1'b0;
    end else if (!pe_n) begin
      q = d; w = 1'b0;
    end else if (cet && cep) begin
      if (!DOWN_EN || dir) begin
        if (q < m - 1) begin q = q + 1; w = 1'b0; end
        else begin q = 0; w = 1'b1; end
      end else begin
        if (q == 0) begin q = m - 1; w = 1'b1; end
        else if (q > m - 1) begin q = m - 1; w = 1'b0; end
        else begin q = q - 1; w = 1'b0; end
      end
    end else begin
      w = 1'b0;
    end
  endtask

  function automatic bit model_tc(input int m, input int q, input bit cet, input bit dir);
    int term;
    term = (DOWN_EN && !dir) ? 0 : m - 1;
    return cet && (q == term);
  endfunction

  // ---------------- instance A: WIDTH=8, MODULUS=10, INIT=3
  logic       a_rst = 1'b1, a_pe_n = 1'b1, a_cet = 1'b0, a_cep = 1'b0, a_dir = 1'b1;
  logic [7:0] a_d = '0, a_q;
  logic       a_tc, a_wrap;
  int         am_q = 3;
  bit         am_w = 1'b0;

  counter_mod_n #(.WIDTH(8), .MODULUS(10), .INIT(3)) u_a (
    .clk(clk), .rst(a_rst), .d(a_d), .pe_n(a_pe_n), .cet(a_cet), .cep(a_cep),
    .dir(a_dir), .q(a_q), .tc(a_tc), .wrap(a_wrap)
  );

  task automatic step_a(input bit rst, input bit pe_n, input bit cet, input bit cep,
                        input bit dir, input int d);
    a_rst = rst; a_pe_n = pe_n; a_cet = cet; a_cep = cep; a_dir = dir; a_d = 8'(d);
    #1;
    check_val("a_tc", int'(a_tc), int'(model_tc(10, am_q, cet, dir)));
    @(posedge clk); #1;
    model_edge(10, 3, rst, pe_n, cet, cep, dir, d, am_q, am_w);
    check_val("a_q", int'(a_q), am_q);
    check_val("a_wrap", int'(a_wrap), int'(am_w));
  endtask

  // ---------------- instance B: WIDTH=4, MODULUS=16 (full range)
  logic       b_rst = 1'b1, b_pe_n = 1'b1, b_cet = 1'b0, b_cep = 1'b0, b_dir = 1'b1;
  logic [3:0] b_d = '0, b_q;
  logic       b_tc, b_wrap;
  int         bm_q = 0;
  bit         bm_w = 1'b0;

  counter_mod_n #(.WIDTH(4), .MODULUS(16), .INIT(0)) u_b (
    .clk(clk), .rst(b_rst), .d(b_d), .pe_n(b_pe_n), .cet(b_cet), .cep(b_cep),
    .dir(b_dir), .q(b_q), .tc(b_tc), .wrap(b_wrap)
  );

  task automatic step_b(input bit rst, input bit pe_n, input bit cet, input bit cep,
                        input bit dir, input int d);
    b_rst = rst; b_pe_n = pe_n; b_cet = cet; b_cep = cep; b_dir = dir; b_d = 4'(d);
    #1;
    check_val("b_tc", int'(b_tc), int'(model_tc(16, bm_q, cet, dir)));
    @(posedge clk); #1;
    model_edge(16, 0, rst, pe_n, cet, cep, dir, d, bm_q, bm_w);
    check_val("b_q", int'(b_q), bm_q);
    check_val("b_wrap", int'(b_wrap), int'(bm_w));
  endtask

  // ---------------- cascade: two MODULUS=10 stages
  logic       c_rst = 1'b1, c_cep = 1'b0;
  logic [3:0] c_q0, c_q1;
  logic       c_tc0, c_tc1, c_wrap0, c_wrap1;

  counter_mod_n #(.WIDTH(4), .MODULUS(10), .INIT(0)) u_c0 (
    .clk(clk), .rst(c_rst), .d(4'd0), .pe_n(1'b1), .cet(1'b1), .cep(c_cep),
    .dir(1'b1), .q(c_q0), .tc(c_tc0), .wrap(c_wrap0)
  );
  counter_mod_n #(.WIDTH(4), .MODULUS(10), .INIT(0)) u_c1 (
    .clk(clk), .rst(c_rst), .d(4'd0), .pe_n(1'b1), .cet(c_tc0), .cep(c_cep),
    .dir(1'b1), .q(c_q1), .tc(c_tc1), .wrap(c_wrap1)
  );

  task automatic run_cascade(input int edges);
    c_rst = 1'b1; c_cep = 1'b0;
    @(posedge clk); #1;
    c_rst = 1'b0; c_cep = 1'b1;
    for (int k = 1; k <= edges; k++) begin
      @(posedge clk); #1;
      check_val("c_value", int'(c_q1) * 10 + int'(c_q0), k % 100);
      if (k % 100 == 99) check_val("c_tc1_at_99", int'(c_tc1), 1);
    end
    c_cep = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int got;
    // Reset and hold.
    #2;
    step_a(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step_a(0, 1, 0, 0, 1, 0);
      check_val("hold_q", int'(a_q), 3);
      check_val("hold_wrap", int'(a_wrap), 0);
      check_val("hold_tc", int'(a_tc), 0);
    end

    // Up wrap from 0: expected sequence 1..9,0,1,2.
    step_a(0, 0, 0, 0, 1, 0);
    for (int v = 1; v <= 9; v++) exp_q.push_back(v);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    for (int i = 0; i < 12; i++) begin
      bit tc_before;
      tc_before = (a_q == 8'd9);
      step_a(0, 1, 1, 1, 1, 0);
      got = exp_q.pop_front();
      check_val("up_seq", int'(a_q), got);
      check_val("up_wrap", int'(a_wrap), (got == 0) ? 1 : 0);
      if (tc_before) check_val("up_tc_prev9", int'(got == 0), 1);
    end

    // Load wins over count; out-of-range load wraps on next up count.
    step_a(0, 0, 1, 1, 1, 200);
    check_val("load_q", int'(a_q), 200);
    check_val("load_wrap", int'(a_wrap), 0);
    step_a(0, 1, 1, 1, 1, 0);
    check_val("oor_up_q", int'(a_q), 0);
    check_val("oor_up_wrap", int'(a_wrap), 1);
    step_a(1, 0, 1, 1, 1, 7);
    check_val("rst_over_load", int'(a_q), 3);

    // Down mode from 1.
    step_a(0, 0, 0, 0, 0, 1);
    if (DOWN_EN) begin exp_q.push_back(0); exp_q.push_back(9); exp_q.push_back(8); end
    else begin exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); end
    for (int i = 0; i < 3; i++) begin
      step_a(0, 1, 1, 1, 0, 0);
      got = exp_q.pop_front();
      check_val("dn_seq", int'(a_q), got);
    end

    // Down from an out-of-range load.
    step_a(0, 0, 0, 0, 0, 77);
    step_a(0, 1, 1, 1, 0, 0);

    // Randomized traffic on A.
    for (int i = 0; i < 400; i++) begin
      int d;
      d = ($urandom_range(1, 0) == 1) ? int'($urandom_range(9, 0)) : int'($urandom_range(255, 0));
      step_a($urandom_range(31, 0) == 0, $urandom_range(7, 0) != 0,
             $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
             $urandom_range(1, 0) == 1, d);
    end

    // Full-range modulus.
    step_b(1, 1, 0, 0, 1, 0);
    step_b(0, 0, 0, 0, 1, 15);
    b_cet = 1'b1; #1;
    check_val("full_tc_cet1", int'(b_tc), 1);
    b_cet = 1'b0; #1;
    check_val("full_tc_cet0", int'(b_tc), 0);
    step_b(0, 1, 1, 1, 1, 0);
    check_val("full_q", int'(b_q), 0);
    check_val("full_wrap", int'(b_wrap), 1);
    for (int i = 0; i < 300; i++) begin
      step_b($urandom_range(31, 0) == 0, $urandom_range(7, 0) != 0,
             $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
             $urandom_range(1, 0) == 1, int'($urandom_range(15, 0)));
    end

    // Cascade.
    run_cascade(100);
    check_val("c100_q1", int'(c_q1), 0);
    check_val("c100_q0", int'(c_q0), 0);
    run_cascade(250);
    check_val("c250_q1", int'(c_q1), 5);
    check_val("c250_q0", int'(c_q0), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
